// File: rtl/bigadd_seq.sv
// Word-serial multi-word adder/subtractor: streams operand word pairs LSW first and
// returns one result word per accepted pair, rippling the carry between words.
module bigadd_seq #(
  parameter int unsigned W    = 256,
  parameter int unsigned MAXW = 16,
  localparam int unsigned LW  = (MAXW > 1) ? $clog2(MAXW) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          sub,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_word,
  output logic          out_last,
  output logic          carry_out,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  word_q, word_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          cout_q, cout_d;

  logic [W-1:0]  operand_b;
  logic [W:0]    sum;
  logic          accept;
  logic          out_fire;

  // Subtraction is A + ~B + 1, with the initial 1 coming from the carry register.
  assign operand_b = sub_q ? ~in_b : in_b;
  assign sum       = {1'b0, in_a} + {1'b0, operand_b} + {{W{1'b0}}, carry_q};

  assign in_ready  = (state_q == StRun) && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_last  = last_q;
  assign carry_out = cout_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    word_d  = word_q;
    valid_d = valid_q;
    last_d  = last_q;
    cout_d  = cout_q;

    if (out_fire) begin
      valid_d = 1'b0;
    end
    // A new word overrides the clear above, so a same-cycle handshake keeps valid high.
    if (accept) begin
      word_d  = sum[W-1:0];
      carry_d = sum[W];
      last_d  = (cnt_q == len_q);
      valid_d = 1'b1;
      cnt_d   = cnt_q + LW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          len_d   = len;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (accept && (cnt_q == len_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_fire && last_q) begin
          state_d = StDone;
          cout_d  = carry_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: doc/bigadd_seq.md
BIGADD_SEQ -- requirements
Module: bigadd_seq

Interface
REQ-001 Parameter W, default 256: operand/result word width in bits.
REQ-002 Parameter MAXW, default 16: maximum words per operation; LW = clog2(MAXW).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin operation; sampled only in IDLE.
REQ-006 len  input  LW  number of words minus one; captured with start.
REQ-007 sub  input  1  0 = A+B, 1 = A-B; captured with start.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 in_valid  input  1  operand word pair valid.
REQ-010 in_ready  output  1  block accepts operand word pair.
REQ-011 in_a, in_b  input  W each  operand words, least-significant word first.
REQ-012 out_valid  output  1  result word valid.
REQ-013 out_ready  input  1  downstream accepts result word.
REQ-014 out_word  output  W  result word, least-significant first.
REQ-015 out_last  output  1  marks final result word; qualified by out_valid.
REQ-016 carry_out  output  1  final carry (sub: 1 = no borrow); valid while done high.
REQ-017 done  output  1  single-cycle pulse after last result word handshake.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; exactly one active.
REQ-019 IDLE -> RUN on start=1: capture len, sub; word counters to 0; carry register = sub.
REQ-020 start while not in IDLE ignored; len/sub changes outside IDLE ignored.
REQ-021 Input handshake: word pair accepted on a cycle with in_valid=1 and in_ready=1.
REQ-022 in_ready = (state==RUN) and (out_valid==0 or out_ready==1); never high in IDLE, DRAIN, DONE.
REQ-023 Per accepted pair: {c, s} = in_a + (sub ? ~in_b : in_b) + carry, width W+1; s to output register, c to carry register, same edge.
REQ-024 Latency: word accepted at edge k has out_valid=1 from edge k onward until out handshake.
REQ-025 Output register holds out_word, out_last stable while out_valid=1 and out_ready=0.
REQ-026 out_last=1 exactly on the word with input index len.
REQ-027 RUN -> DRAIN on edge accepting input word index len; in_ready low from then on.
REQ-028 DRAIN -> DONE on out handshake with out_last=1; carry_out latched from carry register same edge.
REQ-029 DONE -> IDLE unconditionally next edge; done=1 only while in DONE.
REQ-030 Simultaneous out handshake and new input acceptance in RUN: output register reloads with new word, out_valid stays 1.
REQ-031 len=0: single word; RUN -> DRAIN on first acceptance; out_last on first word.
REQ-032 Carry chains only within one operation; never from previous operation.
REQ-033 No input word accepted outside RUN; in_valid in other states has no effect.

Reset
REQ-034 rst_n=0, any state including mid-operation: state IDLE, counters 0, carry 0, out_valid 0, out_last 0, out_word 0, carry_out 0, done 0, busy 0, in_ready 0; partial results discarded.
REQ-035 After rst_n deasserts, no output activity until a new start.

Verification
REQ-036 len=0, sub=0, a=2^W-1, b=1, out_ready=1 -> out_word=0, out_last=1, carry_out=1, done pulse one cycle later.
REQ-037 len=3, sub=0, a words {2^W-1,2^W-1,2^W-1,0}, b words {1,0,0,0} -> outputs {0,0,0,1}, carry_out=0; carry ripples across words.
REQ-038 len=1, sub=1, a={0,1}, b={1,0} -> outputs {2^W-1,0}, carry_out=1; a={0,0}, b={1,0} -> {2^W-1,2^W-1}, carry_out=0.
REQ-039 len=2, out_ready held 0 for 5 cycles after first word -> in_ready=0, out_word stable throughout; correct results after release, no word lost or duplicated.
REQ-040 start pulsed during RUN with different len -> ignored; operation completes with original length.
REQ-041 rst_n asserted after 2 of 4 words -> all outputs at reset values immediately; next operation len=0, a=5, b=7 -> out_word=12, carry_out=0.
